// File: rtl/bcd_range_counter.sv
// bcd_range_counter: N-digit BCD counter that wraps over [MIN_VAL, limit].
// The limit is a runtime input, so one block can serve any clock or calendar field.
// It also provides a checked synchronous load, a registered wrap carry and a
// combinational flag for an invalid limit.
module bcd_range_counter #(
  parameter int N_DIGITS = 2,
  parameter int MIN_VAL  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  up,
  input  logic                  down,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  input  logic [4*N_DIGITS-1:0] limit,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  carry,
  output logic                  load_err,
  output logic                  cfg_err
);

  localparam int W = 4 * N_DIGITS;

  // Convert an integer into packed BCD. Digit 0 is the units digit.
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           rem;
    r   = '0;
    rem = v;
    for (int k = 0; k < N_DIGITS; k++) begin
      r[4*k +: 4] = 4'(rem % 32'sd10);
      rem         = rem / 32'sd10;
    end
    return r;
  endfunction

  // Return true when every digit is a legal BCD code (0..9).
  function automatic logic bcd_valid(input logic [W-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (b[4*k +: 4] > 4'd9) ok = 1'b0;
      else                    ok = ok;
    end
    return ok;
  endfunction

  // Decode BCD to binary. 16 bits hold 9999, so every legal N_DIGITS fits.
  function automatic logic [15:0] bcd_to_bin(input logic [W-1:0] b);
    logic [15:0] acc;
    acc = 16'd0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      acc = acc * 16'd10 + 16'(b[4*k +: 4]);
    end
    return acc;
  endfunction

  // Increment a BCD value. A units digit at 9 becomes 0 and ripples into the next digit.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c;
    r = b;
    c = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = r[4*k +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        c = 1'b0;
      end
    end
    return r;
  endfunction

  // Decrement a BCD value. A digit at 0 becomes 9 and borrows from the next digit.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c;
    r = b;
    c = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = r[4*k +: 4] - 4'd1;
          c           = 1'b0;
        end
      end else begin
        c = 1'b0;
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
  localparam logic [15:0]  MIN_BIN = 16'(MIN_VAL);

  logic [W-1:0] count_r;
  logic         carry_r;
  logic         load_err_r;

  logic [15:0]  count_bin_s;
  logic [15:0]  limit_bin_s;
  logic [15:0]  load_bin_s;
  logic         limit_ok_s;
  logic         load_ok_s;
  logic         at_top_s;
  logic         at_bottom_s;
  logic         above_top_s;
  logic [W-1:0] count_nxt_s;
  logic         carry_nxt_s;
  logic         load_err_nxt_s;

  // Decode the operands and derive the range conditions.
  // While the limit is invalid, a load is only checked against the lower bound.
  always_comb begin
    count_bin_s = bcd_to_bin(count_r);
    limit_bin_s = bcd_to_bin(limit);
    load_bin_s  = bcd_to_bin(load_val);
    limit_ok_s  = bcd_valid(limit) && (limit_bin_s >= MIN_BIN);
    load_ok_s   = bcd_valid(load_val) && (load_bin_s >= MIN_BIN) &&
                  (!limit_ok_s || (load_bin_s <= limit_bin_s));
    at_top_s    = (count_bin_s >= limit_bin_s);
    at_bottom_s = (count_bin_s <= MIN_BIN);
    above_top_s = (count_bin_s > limit_bin_s);
  end

  // Choose the next state. Priority is load, then tick, then up/down.
  always_comb begin
    count_nxt_s    = count_r;
    carry_nxt_s    = 1'b0;
    load_err_nxt_s = 1'b0;
    if (load) begin
      if (load_ok_s) count_nxt_s    = load_val;
      else           load_err_nxt_s = 1'b1;
    end else if (!limit_ok_s) begin
      count_nxt_s = count_r;
    end else if (tick) begin
      if (at_top_s) begin
        count_nxt_s = MIN_BCD;
        carry_nxt_s = 1'b1;
      end else begin
        count_nxt_s = bcd_inc(count_r);
      end
    end else if (up && !down) begin
      if (at_top_s) count_nxt_s = MIN_BCD;
      else          count_nxt_s = bcd_inc(count_r);
    end else if (down && !up) begin
      if (at_bottom_s || above_top_s) count_nxt_s = limit;
      else                            count_nxt_s = bcd_dec(count_r);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Update the state registers. Synchronous reset returns the counter to MIN_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= MIN_BCD;
      carry_r    <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      carry_r    <= carry_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign count    = count_r;
  assign carry    = carry_r;
  assign load_err = load_err_r;
  assign cfg_err  = !limit_ok_s;

endmodule

// File: tb/tb_bcd_range_counter.sv
// Testbench for bcd_range_counter. It runs two instances, with MIN_VAL 0 and 1,
// from shared stimulus. Each instance is checked against a decimal-level reference
// model on directed and random cycles.
module tb_bcd_range_counter;

  logic       clk = 1'b0;
  logic       rst, tick, up, down, load;
  logic [7:0] load_val, limit;
  logic [7:0] count0, count1;
  logic       carry0, carry1, load_err0, load_err1, cfg_err0, cfg_err1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state per instance: decimal count, carry, load_err.
  int m_cnt   [2];
  int m_carry [2];
  int m_lerr  [2];
  int m_min   [2] = '{0, 1};

  always #5 clk = ~clk;

  bcd_range_counter #(.N_DIGITS(2), .MIN_VAL(0)) u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .down(down), .load(load),
    .load_val(load_val), .limit(limit), .count(count0), .carry(carry0),
    .load_err(load_err0), .cfg_err(cfg_err0)
  );

  bcd_range_counter #(.N_DIGITS(2), .MIN_VAL(1)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .down(down), .load(load),
    .load_val(load_val), .limit(limit), .count(count1), .carry(carry1),
    .load_err(load_err1), .cfg_err(cfg_err1)
  );

  function automatic logic is_bcd(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int to_dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd8(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model of instance i by one clock edge.
  task automatic model_step(input int i);
    int  lim, lv;
    logic lim_ok, ld_ok;
    lim    = to_dec(limit);
    lv     = to_dec(load_val);
    lim_ok = is_bcd(limit) && (lim >= m_min[i]);
    m_carry[i] = 0;
    m_lerr[i]  = 0;
    if (rst) begin
      m_cnt[i] = m_min[i];
    end else if (load) begin
      ld_ok = is_bcd(load_val) && (lv >= m_min[i]) && (!lim_ok || lv <= lim);
      if (ld_ok) m_cnt[i] = lv;
      else       m_lerr[i] = 1;
    end else if (!lim_ok) begin
      m_cnt[i] = m_cnt[i];
    end else if (tick) begin
      if (m_cnt[i] >= lim) begin
        m_cnt[i]   = m_min[i];
        m_carry[i] = 1;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end else if (up && !down) begin
      m_cnt[i] = (m_cnt[i] >= lim) ? m_min[i] : m_cnt[i] + 1;
    end else if (down && !up) begin
      m_cnt[i] = (m_cnt[i] <= m_min[i] || m_cnt[i] > lim) ? lim : m_cnt[i] - 1;
    end
  endtask

  // Apply one cycle of inputs, check cfg_err, clock once, then check the registered outputs.
  task automatic step(input logic r, input logic t, input logic u, input logic d,
                      input logic l, input logic [7:0] lv, input logic [7:0] lim);
    logic lim_bcd;
    rst = r; tick = t; up = u; down = d; load = l; load_val = lv; limit = lim;
    #1;
    lim_bcd = is_bcd(lim);
    chk("cfg_err0", 32'(cfg_err0), 32'(!(lim_bcd && to_dec(lim) >= 0)));
    chk("cfg_err1", 32'(cfg_err1), 32'(!(lim_bcd && to_dec(lim) >= 1)));
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk("count0",    32'(count0),    32'(to_bcd8(m_cnt[0])));
    chk("carry0",    32'(carry0),    32'(m_carry[0]));
    chk("load_err0", 32'(load_err0), 32'(m_lerr[0]));
    chk("count1",    32'(count1),    32'(to_bcd8(m_cnt[1])));
    chk("carry1",    32'(carry1),    32'(m_carry[1]));
    chk("load_err1", 32'(load_err1), 32'(m_lerr[1]));
  endtask

  // Directed scenarios first, then random traffic.
  initial begin
    logic [7:0] lims [6] = '{8'h23, 8'h59, 8'h31, 8'h28, 8'h12, 8'h99};
    logic [7:0] lim_r, lv_r;
    int         p;

    // Reset.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h23);
    chk("rst_cnt0", 32'(count0), 32'h00);
    chk("rst_cnt1", 32'(count1), 32'h01);

    // Hour wrap 22 -> 23 -> 00, with carry for exactly one cycle.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 8'h23);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h23);
    chk("hr_23", 32'(count0), 32'h23);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h23);
    chk("hr_wrap", 32'(count0), 32'h00);
    chk("hr_carry", 32'(carry0), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h23);
    chk("hr_carry_off", 32'(carry0), 32'h0);

    // Day: digit ripple, then wrap from 31 to 01.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 8'h31);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h31);
    chk("day_ripple", 32'(count1), 32'h10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31, 8'h31);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h31);
    chk("day_wrap", 32'(count1), 32'h01);
    chk("day_carry", 32'(carry1), 32'h1);

    // Down from 00 goes to the limit, then up wraps back to 00. Neither sets carry.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h23);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h23);
    chk("down_wrap", 32'(count0), 32'h23);
    chk("down_nocarry", 32'(carry0), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h23);
    chk("up_wrap", 32'(count0), 32'h00);
    chk("up_nocarry", 32'(carry0), 32'h0);

    // Count 30 above a limit lowered to 28: tick wraps to MIN, down goes to the limit.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 8'h31);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h28);
    chk("low_lim_tick", 32'(count1), 32'h01);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 8'h31);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h28);
    chk("low_lim_down", 32'(count1), 32'h28);

    // Load checks: a non-BCD value and a value above the limit are rejected; a good one is accepted.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1A, 8'h23);
    chk("ld_nonbcd_err", 32'(load_err0), 32'h1);
    chk("ld_nonbcd_hold", 32'(count0), 32'h28);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h24, 8'h23);
    chk("ld_over_err", 32'(load_err0), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h15, 8'h23);
    chk("ld_ok", 32'(count0), 32'h15);
    chk("ld_ok_err", 32'(load_err0), 32'h0);

    // tick and up in the same cycle give a single increment.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h23);
    chk("tick_up", 32'(count0), 32'h16);

    // rst overrides a wrapping tick: count goes to MIN with no carry.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h23, 8'h23);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h23);
    chk("rst_tick_cnt", 32'(count0), 32'h00);
    chk("rst_tick_carry", 32'(carry0), 32'h0);

    // An invalid limit raises cfg_err and tick is ignored.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 8'h23);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0F);
    chk("cfg_hold", 32'(count0), 32'h07);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) lim_r = 8'($urandom_range(0, 255));
      else                           lim_r = lims[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 0) lv_r = 8'($urandom_range(0, 255));
      else                           lv_r = to_bcd8($urandom_range(0, 99));
      p = $urandom_range(0, 99);
      step(1'b0 ? 1'b0 : (p < 2),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0),
           (p >= 2 && p < 12),
           lv_r, lim_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
